// File: rtl/delay_timer_arbiter.sv
// Shared tick-based delay timer with round-robin arbitration between two requesters.
// A prescaler derives ticks from clk_50M; the granted requester gets a one-cycle done pulse.
module delay_timer_arbiter #(
   parameter int unsigned WIDTH    = 12,
   parameter int unsigned PRESCALE = 25000
) (
   input  logic             clk_50M,
   input  logic             i_Reset,
   input  logic             i_ReqA,
   input  logic [WIDTH-1:0] i_LenA,
   input  logic             i_ReqB,
   input  logic [WIDTH-1:0] i_LenB,
   input  logic             i_Abort,
   output logic             o_GntA,
   output logic             o_GntB,
   output logic             o_DoneA,
   output logic             o_DoneB,
   output logic             o_Busy,
   output logic             o_Tick,
   output logic [WIDTH-1:0] o_Count
);

   localparam int unsigned PW = $clog2(PRESCALE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [PW-1:0]    presc, presc_n;
   logic [WIDTH-1:0] len, len_n;
   logic [WIDTH-1:0] count, count_n;
   logic             gnt_a, gnt_a_n;
   logic             gnt_b, gnt_b_n;
   logic             done_a, done_a_n;
   logic             done_b, done_b_n;
   logic             busy_n;
   logic             tick, tick_n;
   logic             last_b, last_b_n;   // 1 when B was served most recently
   logic             pick_a;
   logic             owner_req;

   // State and datapath registers
   always_ff @(posedge clk_50M) begin
      if (!i_Reset) begin
         state  <= IDLE;
         presc  <= '0;
         len    <= '0;
         count  <= '0;
         gnt_a  <= 1'b0;
         gnt_b  <= 1'b0;
         done_a <= 1'b0;
         done_b <= 1'b0;
         o_Busy <= 1'b0;
         tick   <= 1'b0;
         last_b <= 1'b1;
      end else begin
         state  <= state_n;
         presc  <= presc_n;
         len    <= len_n;
         count  <= count_n;
         gnt_a  <= gnt_a_n;
         gnt_b  <= gnt_b_n;
         done_a <= done_a_n;
         done_b <= done_b_n;
         o_Busy <= busy_n;
         tick   <= tick_n;
         last_b <= last_b_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      presc_n   = presc;
      len_n     = len;
      count_n   = count;
      gnt_a_n   = gnt_a;
      gnt_b_n   = gnt_b;
      done_a_n  = 1'b0;
      done_b_n  = 1'b0;
      tick_n    = 1'b0;
      last_b_n  = last_b;
      pick_a    = i_ReqA && (!i_ReqB || last_b);
      owner_req = gnt_a ? i_ReqA : i_ReqB;

      case (state)
         IDLE: begin
            if (i_ReqA || i_ReqB) begin
               gnt_a_n  = pick_a;
               gnt_b_n  = !pick_a;
               last_b_n = !pick_a;
               len_n    = pick_a ? i_LenA : i_LenB;
               count_n  = '0;
               presc_n  = '0;
               state_n  = (len_n == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // Cancel takes priority over completion
            if (i_Abort || !owner_req) begin
               state_n = IDLE;
               gnt_a_n = 1'b0;
               gnt_b_n = 1'b0;
            end else if (count == len) begin
               state_n  = DONE;
               done_a_n = gnt_a;
               done_b_n = gnt_b;
            end else if (presc == PW'(PRESCALE - 1)) begin
               presc_n = '0;
               tick_n  = 1'b1;
               count_n = count + WIDTH'(1);
            end else begin
               presc_n = presc + PW'(1);
            end
         end
         DONE: begin
            // Zero-length grants arrive here without a pulse yet; issue it first
            if (done_a || done_b) begin
               state_n = IDLE;
               gnt_a_n = 1'b0;
               gnt_b_n = 1'b0;
            end else begin
               done_a_n = gnt_a;
               done_b_n = gnt_b;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_a_n = 1'b0;
            gnt_b_n = 1'b0;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   assign o_GntA  = gnt_a;
   assign o_GntB  = gnt_b;
   assign o_DoneA = done_a;
   assign o_DoneB = done_b;
   assign o_Tick  = tick;
   assign o_Count = count;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed self-checking bench for delay_timer_arbiter with PRESCALE=4, WIDTH=12.
module tb_delay_timer_arbiter;

   localparam int unsigned WIDTH    = 12;
   localparam int unsigned PRESCALE = 4;

   logic             clk_50M = 1'b0;
   logic             i_Reset;
   logic             i_ReqA;
   logic [WIDTH-1:0] i_LenA;
   logic             i_ReqB;
   logic [WIDTH-1:0] i_LenB;
   logic             i_Abort;
   logic             o_GntA, o_GntB, o_DoneA, o_DoneB, o_Busy, o_Tick;
   logic [WIDTH-1:0] o_Count;

   int checks   = 0;
   int failures = 0;

   delay_timer_arbiter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk_50M (clk_50M),
      .i_Reset (i_Reset),
      .i_ReqA  (i_ReqA),
      .i_LenA  (i_LenA),
      .i_ReqB  (i_ReqB),
      .i_LenB  (i_LenB),
      .i_Abort (i_Abort),
      .o_GntA  (o_GntA),
      .o_GntB  (o_GntB),
      .o_DoneA (o_DoneA),
      .o_DoneB (o_DoneB),
      .o_Busy  (o_Busy),
      .o_Tick  (o_Tick),
      .o_Count (o_Count)
   );

   always #10 clk_50M = ~clk_50M;

   // One rising edge, then settle at the falling edge for sampling and driving
   task automatic step();
      @(posedge clk_50M);
      @(negedge clk_50M);
   endtask

   task automatic apply_reset();
      @(negedge clk_50M);
      i_Reset = 1'b0;
      repeat (3) @(posedge clk_50M);
      @(negedge clk_50M);
      i_Reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [17:0] obs;
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         obs = {o_GntA, o_GntB, o_DoneA, o_DoneB, o_Busy, o_Tick, o_Count};
         checks++;
         if (obs !== 18'd0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: got %h want 0", i, obs);
         end
         step();
      end
   endtask

   task automatic test_single();
      logic exp_tick, exp_done, exp_gnt;
      logic [WIDTH-1:0] exp_cnt;
      i_ReqA = 1'b1; i_LenA = 12'd3;
      step();  // e0
      checks++;
      if ({o_GntA, o_GntB, o_Busy, o_Count} !== {3'b101, 12'd0}) begin
         failures++;
         $display("FAIL single_grant: gnt=%b%b busy=%b cnt=%0d want 1 0 1 0", o_GntA, o_GntB, o_Busy, o_Count);
      end
      i_LenA = 12'd9;  // ignored after the grant edge
      for (int k = 1; k <= 14; k++) begin
         step();
         exp_tick = (k % 4 == 0) && (k <= 12);
         exp_done = (k == 13);
         exp_gnt  = (k <= 13);
         exp_cnt  = (k >= 12) ? 12'd3 : WIDTH'(k / 4);
         checks++;
         if ({o_Tick, o_DoneA, o_GntA, o_Busy, o_Count} !== {exp_tick, exp_done, exp_gnt, exp_gnt, exp_cnt}) begin
            failures++;
            $display("FAIL single_seq e0+%0d: tick=%b done=%b gnt=%b busy=%b cnt=%0d want %b %b %b %b %0d",
                     k, o_Tick, o_DoneA, o_GntA, o_Busy, o_Count, exp_tick, exp_done, exp_gnt, exp_gnt, exp_cnt);
         end
         if (k == 13) i_ReqA = 1'b0;
      end
   endtask

   task automatic test_tie();
      apply_reset();
      i_ReqA = 1'b1; i_ReqB = 1'b1; i_LenA = 12'd2; i_LenB = 12'd2;
      step();
      checks++;
      if ({o_GntA, o_GntB} !== 2'b10) begin
         failures++;
         $display("FAIL tie_first: gnt=%b%b want 10", o_GntA, o_GntB);
      end
      repeat (9) step();
      checks++;
      if ({o_DoneA, o_GntB} !== 2'b10) begin
         failures++;
         $display("FAIL tie_doneA: done=%b gntB=%b want 1 0", o_DoneA, o_GntB);
      end
      i_ReqA = 1'b0;
      step();
      checks++;
      if ({o_GntA, o_GntB, o_Busy} !== 3'b000) begin
         failures++;
         $display("FAIL tie_gap: gnt=%b%b busy=%b want 000", o_GntA, o_GntB, o_Busy);
      end
      step();
      checks++;
      if ({o_GntA, o_GntB, o_Count} !== {2'b01, 12'd0}) begin
         failures++;
         $display("FAIL tie_second: gnt=%b%b cnt=%0d want 01 0", o_GntA, o_GntB, o_Count);
      end
      repeat (9) step();
      checks++;
      if ({o_DoneB, o_DoneA, o_Count} !== {2'b10, 12'd2}) begin
         failures++;
         $display("FAIL tie_doneB: doneB=%b doneA=%b cnt=%0d want 1 0 2", o_DoneB, o_DoneA, o_Count);
      end
      i_ReqB = 1'b0;
      step();
      i_ReqA = 1'b1; i_ReqB = 1'b1;
      step();
      checks++;
      if ({o_GntA, o_GntB} !== 2'b10) begin
         failures++;
         $display("FAIL tie_rr: gnt=%b%b want 10", o_GntA, o_GntB);
      end
      i_ReqA = 1'b0; i_ReqB = 1'b0;
      step();
      checks++;
      if ({o_GntA, o_GntB, o_Busy} !== 3'b000) begin
         failures++;
         $display("FAIL tie_release: gnt=%b%b busy=%b want 000", o_GntA, o_GntB, o_Busy);
      end
   endtask

   task automatic test_zero();
      i_ReqB = 1'b1; i_LenB = 12'd0;
      step();
      checks++;
      if ({o_GntB, o_DoneB, o_Busy} !== 3'b101) begin
         failures++;
         $display("FAIL zero_grant: gnt=%b done=%b busy=%b want 1 0 1", o_GntB, o_DoneB, o_Busy);
      end
      step();
      checks++;
      if ({o_GntB, o_DoneB, o_Tick, o_Count} !== {3'b110, 12'd0}) begin
         failures++;
         $display("FAIL zero_done: gnt=%b done=%b tick=%b cnt=%0d want 1 1 0 0", o_GntB, o_DoneB, o_Tick, o_Count);
      end
      i_ReqB = 1'b0;
      step();
      checks++;
      if ({o_GntB, o_DoneB, o_Busy} !== 3'b000) begin
         failures++;
         $display("FAIL zero_exit: gnt=%b done=%b busy=%b want 000", o_GntB, o_DoneB, o_Busy);
      end
   endtask

   // mode 0: i_Abort, mode 1: owner request drop
   task automatic test_cancel(input int mode);
      i_ReqA = 1'b1; i_LenA = 12'd5;
      step();
      repeat (5) step();
      if (mode == 0) i_Abort = 1'b1;
      else           i_ReqA  = 1'b0;
      step();
      i_Abort = 1'b0; i_ReqA = 1'b0;
      checks++;
      if ({o_GntA, o_Busy, o_DoneA, o_Count} !== {3'b000, 12'd1}) begin
         failures++;
         $display("FAIL cancel_m%0d: gnt=%b busy=%b done=%b cnt=%0d want 0 0 0 1", mode, o_GntA, o_Busy, o_DoneA, o_Count);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({o_DoneA, o_Busy, o_Count} !== {2'b00, 12'd1}) begin
            failures++;
            $display("FAIL cancel_hold_m%0d: done=%b busy=%b cnt=%0d want 0 0 1", mode, o_DoneA, o_Busy, o_Count);
         end
      end
   endtask

   task automatic test_abort_at_end();
      i_ReqA = 1'b1; i_LenA = 12'd2;
      step();
      repeat (8) step();
      checks++;
      if ({o_Count, o_Busy} !== {12'd2, 1'b1}) begin
         failures++;
         $display("FAIL abort_end_pre: cnt=%0d busy=%b want 2 1", o_Count, o_Busy);
      end
      i_Abort = 1'b1;
      step();
      i_Abort = 1'b0; i_ReqA = 1'b0;
      checks++;
      if ({o_DoneA, o_GntA, o_Busy, o_Count} !== {3'b000, 12'd2}) begin
         failures++;
         $display("FAIL abort_end: done=%b gnt=%b busy=%b cnt=%0d want 0 0 0 2", o_DoneA, o_GntA, o_Busy, o_Count);
      end
      step();
      checks++;
      if (o_DoneA !== 1'b0) begin
         failures++;
         $display("FAIL abort_end_late: done=%b want 0", o_DoneA);
      end
   endtask

   task automatic test_midrun_reset();
      i_ReqA = 1'b1; i_LenA = 12'd5;
      step();
      i_ReqB = 1'b1; i_LenB = 12'd7;
      repeat (8) step();
      checks++;
      if ({o_Count, o_GntA, o_GntB} !== {12'd2, 2'b10}) begin
         failures++;
         $display("FAIL midrun_pre: cnt=%0d gnt=%b%b want 2 10", o_Count, o_GntA, o_GntB);
      end
      i_Reset = 1'b0; i_ReqA = 1'b0;
      step();
      checks++;
      if ({o_GntA, o_GntB, o_DoneA, o_DoneB, o_Busy, o_Tick, o_Count} !== 18'd0) begin
         failures++;
         $display("FAIL midrun_reset: outputs=%b want all 0",
                  {o_GntA, o_GntB, o_DoneA, o_DoneB, o_Busy, o_Tick, o_Count});
      end
      i_Reset = 1'b1;
      step();
      checks++;
      if ({o_GntA, o_GntB, o_Busy, o_Count} !== {3'b011, 12'd0}) begin
         failures++;
         $display("FAIL midrun_regrant: gnt=%b%b busy=%b cnt=%0d want 01 1 0", o_GntA, o_GntB, o_Busy, o_Count);
      end
      i_ReqB = 1'b0;
      step();
      checks++;
      if ({o_GntB, o_DoneB, o_Busy} !== 3'b000) begin
         failures++;
         $display("FAIL midrun_cancelB: gnt=%b done=%b busy=%b want 000", o_GntB, o_DoneB, o_Busy);
      end
   endtask

   initial begin
      i_Reset = 1'b0;
      i_ReqA  = 1'b0;
      i_ReqB  = 1'b0;
      i_LenA  = '0;
      i_LenB  = '0;
      i_Abort = 1'b0;
      test_reset();
      test_single();
      test_tie();
      test_zero();
      test_cancel(0);
      test_cancel(1);
      test_abort_at_end();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
